nor_flash_reader: RTL and testbench
===================================

Name: nor_flash_reader

Overview:
- Read-only controller for the parallel NOR flash in 8-bit byte mode.
- Performs the flash power-up sequence: hold reset, release, recover, enable chip.
- Then serves 32-bit word read requests from the instruction-fetch side by issuing four byte reads with programmable access wait.
- Sits between the core's fetch/load path and the flash pins. The flash pin outputs connect directly to the board.

Parameters:
- ADDR_W, 27, flash byte-address width.
- RST_CYCLES, 15000, clock cycles nMEMRST is held low after reset deassertion.
- RST_RECOVER_CYCLES, 2, cycles between nMEMRST rising and nCE falling.
- ACCESS_CYCLES, 4, clock edges per byte from address change to data sample; minimum 1; 4 at 50 MHz covers tACC 70 ns.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  read request.
- req_addr  in  ADDR_W  byte address; low 2 bits ignored.
- req_ready  out  1  controller can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  32  little-endian word.
- init_done  out  1  power-up sequence complete.
- RDY_BSY  in  1  flash ready (1) / busy (0); asynchronous pin.
- nMEMRST  out  1  flash reset, active low.
- nBYTE  out  1  tied 0 (byte mode).
- nCE  out  1  chip enable, active low.
- nWE  out  1  write enable; held 1 (no writes).
- nOE  out  1  output enable, active low.
- ADDR  out  ADDR_W  flash address.
- DATA  in  8  flash data bus (read only).

Behaviour:
- One clock; reset is asynchronous and active-high: clk is the clock, rst the reset.
- Reset values:
  - nMEMRST=0, nBYTE=0, nCE=1, nWE=1, nOE=1, ADDR=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, init_done=0.
  - state=RESET_HOLD, counters=0.
- rst asserted at any time, including mid-read: all outputs take reset values immediately. The in-flight request is dropped with no response. The init sequence restarts from RESET_HOLD.
- RDY_BSY passes through a 2-flop synchroniser; rdy_s below means the synchronised value.
- States:
  - RESET_HOLD: count edges; at edge RST_CYCLES after rst deassertion, nMEMRST<=1 and go to RECOVER.
  - RECOVER: after RST_RECOVER_CYCLES edges, nCE<=0 and go to WAIT_RDY. nCE then stays 0 until reset.
  - WAIT_RDY: when rdy_s=1, init_done<=1 and go to IDLE. init_done stays 1 until reset.
  - IDLE: req_ready = rdy_s (combinational from state and rdy_s).
    - On req_valid && req_ready: base = {req_addr[ADDR_W-1:2], 2'b00}; ADDR<=base; nOE<=0; cnt<=ACCESS_CYCLES; k<=0; go to READ.
  - READ: each edge decrements cnt. On the edge where cnt==1:
    - Sample DATA into byte lane k (rsp_data[8k+7:8k]).
    - If k<3: ADDR<=base+k+1, cnt<=ACCESS_CYCLES, k<=k+1; nOE stays 0.
    - If k==3: nOE<=1, rsp_valid<=1, go to RESPOND.
  - RESPOND: rsp_valid<=0, go to IDLE. req_ready is 0 in this state.
- Latency: accept edge E0 -> sample edges at E0+ACCESS_CYCLES*(k+1) -> rsp_valid high during the cycle after E0+4*ACCESS_CYCLES (one cycle only). Next accept is possible at E0+4*ACCESS_CYCLES+2.
- rsp_data holds its last value until the next response. The consumer has no backpressure and must capture on the pulse.
- RDY_BSY falling during READ is ignored; the read completes.
- ADDR arithmetic wraps only within the aligned word (base+0..3). The top word 0x7FFFFFC reads 0x7FFFFFC..0x7FFFFFF with no overflow.
- req_addr is sampled only on the accept edge; changes afterwards are ignored.

Decomposition:
- Package nor_flash_pkg contains:
  - state encoding (RESET_HOLD, RECOVER, WAIT_RDY, IDLE, READ, RESPOND), 3 bits;
  - BYTES_PER_WORD=4;
  - default timing constants.
- One sub-module, nor_sync2: a 2-flop synchroniser for RDY_BSY, reset to 0 by rst.

Test Plan:
1. Power-up with defaults, RDY_BSY=1 -> nMEMRST rises at edge 15000 after rst falls; nCE falls 2 edges later; init_done=1 within 3 further edges; nWE=1 and nBYTE=0 throughout.
2. Flash model returns bytes 0x11,0x22,0x33,0x44 at 0x0000100..103; request 0x0000100 -> ADDR steps 0x100..0x103 every 4 cycles; nOE low 16 cycles; rsp_data=0x44332211 on a 1-cycle rsp_valid, 17 cycles after accept.
3. Misaligned request 0x0000103 -> same ADDR sequence 0x100..0x103 and same data as scenario 2; top-of-range request 0x7FFFFFF -> ADDR 0x7FFFFFC..0x7FFFFFF.
4. RDY_BSY=0 while in IDLE with req_valid=1 -> req_ready stays 0, no ADDR change; RDY_BSY=1 -> accept 2 cycles later (synchroniser delay) and the read completes normally.
5. rst pulsed at the 2nd byte of a read -> nOE=1, nCE=1, nMEMRST=0, rsp_valid=0 immediately; no response issued; the full init sequence repeats.
6. Back-to-back requests with req_valid held high -> accepts exactly 18 cycles apart; req_ready=0 during rsp_valid and RESPOND.

Source files
------------

// File: rtl/nor_flash_pkg.sv
// Shared types and default timing for the NOR flash byte-mode read controller.
package nor_flash_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    RECOVER    = 3'd1,
    WAIT_RDY   = 3'd2,
    IDLE       = 3'd3,
    READ       = 3'd4,
    RESPOND    = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD             = 4;
  localparam int DEF_ADDR_W                 = 27;
  localparam int DEF_RST_CYCLES             = 15000;
  localparam int DEF_RST_RECOVER_CYCLES     = 2;
  localparam int DEF_ACCESS_CYCLES          = 4;

  // One shared counter serves every timed phase, so size it for the longest one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nor_sync2.sv
// Two-flop synchroniser for the asynchronous flash ready/busy pin.
module nor_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/nor_flash_reader.sv
// Power-up sequencing and 32-bit word reads (four byte accesses) for a byte-mode parallel NOR flash.
module nor_flash_reader
  import nor_flash_pkg::*;
#(
  parameter int ADDR_W             = DEF_ADDR_W,
  parameter int RST_CYCLES         = DEF_RST_CYCLES,
  parameter int RST_RECOVER_CYCLES = DEF_RST_RECOVER_CYCLES,
  parameter int ACCESS_CYCLES      = DEF_ACCESS_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              init_done,
  input  logic              RDY_BSY,
  output logic              nMEMRST,
  output logic              nBYTE,
  output logic              nCE,
  output logic              nWE,
  output logic              nOE,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        DATA
);

  localparam int CNT_W = cnt_width(RST_CYCLES, RST_RECOVER_CYCLES, ACCESS_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              nmemrst_q, nmemrst_d;
  logic              nce_q, nce_d;
  logic              noe_q, noe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              init_done_q, init_done_d;
  logic              rdy_s;

  nor_sync2 u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d_i (RDY_BSY),
    .q_o (rdy_s)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    addr_d      = addr_q;
    word_d      = word_q;
    rsp_data_d  = rsp_data_q;
    nmemrst_d   = nmemrst_q;
    nce_d       = nce_q;
    noe_d       = noe_q;
    rsp_valid_d = 1'b0;
    init_done_d = init_done_q;
    req_ready   = 1'b0;

    unique case (state_q)
      RESET_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          nmemrst_d = 1'b1;
          cnt_d     = '0;
          state_d   = RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(RST_RECOVER_CYCLES - 1)) begin
          nce_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        req_ready = rdy_s;
        if (req_valid && rdy_s) begin
          addr_d      = req_addr;
          addr_d[1:0] = 2'b00;
          noe_d       = 1'b0;
          cnt_d       = CNT_W'(ACCESS_CYCLES);
          k_d         = 2'd0;
          state_d     = READ;
        end
      end
      READ: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (k_q != 2'(BYTES_PER_WORD - 1)) begin
            word_d[8*k_q +: 8] = DATA;
            // Address steps stay inside the aligned word; only the low two bits ever change.
            addr_d[1:0] = k_q + 2'd1;
            cnt_d       = CNT_W'(ACCESS_CYCLES);
            k_d         = k_q + 2'd1;
          end else begin
            rsp_data_d  = {DATA, word_q};
            noe_d       = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESPOND;
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      k_q         <= 2'd0;
      addr_q      <= '0;
      word_q      <= '0;
      rsp_data_q  <= '0;
      nmemrst_q   <= 1'b0;
      nce_q       <= 1'b1;
      noe_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      rsp_data_q  <= rsp_data_d;
      nmemrst_q   <= nmemrst_d;
      nce_q       <= nce_d;
      noe_q       <= noe_d;
      rsp_valid_q <= rsp_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign nMEMRST   = nmemrst_q;
  assign nBYTE     = 1'b0;
  assign nCE       = nce_q;
  assign nWE       = 1'b1;
  assign nOE       = noe_q;
  assign ADDR      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_nor_flash_reader.sv
// Self-checking bench: cycle-by-cycle comparison against a timeline model plus directed literal checks.
`timescale 1ns/1ps
module tb_nor_flash_reader;

  localparam int AW   = 27;
  localparam int RSTC = 15000;
  localparam int RRC  = 2;
  localparam int ACC  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          RDY_BSY = 1'b1;
  logic          req_ready, rsp_valid, init_done;
  logic [31:0]   rsp_data;
  logic          nMEMRST, nBYTE, nCE, nWE, nOE;
  logic [AW-1:0] ADDR;
  logic [7:0]    DATA;

  int checks = 0;
  int failures = 0;
  int e;

  nor_flash_reader #(
    .ADDR_W(AW), .RST_CYCLES(RSTC), .RST_RECOVER_CYCLES(RRC), .ACCESS_CYCLES(ACC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done), .RDY_BSY(RDY_BSY), .nMEMRST(nMEMRST), .nBYTE(nBYTE),
    .nCE(nCE), .nWE(nWE), .nOE(nOE), .ADDR(ADDR), .DATA(DATA)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input logic [AW-1:0] a);
    case (a)
      27'h0000100: return 8'h11;
      27'h0000101: return 8'h22;
      27'h0000102: return 8'h33;
      27'h0000103: return 8'h44;
      default:     return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(input logic [AW-1:0] b);
    return {flash_byte(b + 27'd3), flash_byte(b + 27'd2), flash_byte(b + 27'd1), flash_byte(b)};
  endfunction

  // The flash drives a junk pattern unless both chip and output enables are active.
  assign DATA = (!nCE && !nOE) ? flash_byte(ADDR) : 8'hEE;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Edges counted since the last reset release.
  always @(posedge clk) begin
    if (rst) e <= 0;
    else     e <= e + 1;
  end

  // Timeline model: outputs follow from edge counts, the synchronised ready history and accepted requests.
  logic          h1, h2, rdy_s_m, last_rdy_s, init_m, act_m, busy, ready_exp, noe_m, rv_m;
  int            e0, j, step_n;
  logic [AW-1:0] base_m, addr_m;
  logic [31:0]   word_m, rsp_m;

  always @(negedge clk) begin
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; last_rdy_s = 1'b0;
      init_m = 1'b0; act_m = 1'b0; addr_m = '0; rsp_m = '0;
      check("cycle_reset",
            {nMEMRST, nBYTE, nCE, nWE, nOE, req_ready, rsp_valid, init_done, ADDR, rsp_data},
            {8'b0011_1000, {AW{1'b0}}, 32'h0});
    end else begin
      rdy_s_m = h2;
      h2 = h1;
      h1 = RDY_BSY;
      if (!init_m && e >= RSTC + RRC + 1 && last_rdy_s) init_m = 1'b1;
      last_rdy_s = rdy_s_m;
      noe_m = 1'b1;
      rv_m  = 1'b0;
      busy  = 1'b0;
      if (act_m) begin
        j = e - e0;
        busy = (j <= 4 * ACC);
        if (j < 4 * ACC) begin
          noe_m  = 1'b0;
          step_n = (j / ACC > 3) ? 3 : j / ACC;
          addr_m = base_m + AW'(step_n);
        end else if (j == 4 * ACC) begin
          rv_m   = 1'b1;
          rsp_m  = word_m;
          addr_m = base_m + 27'd3;
        end
        if (j >= 4 * ACC) act_m = 1'b0;
      end
      ready_exp = init_m && !busy && rdy_s_m;
      check("cycle",
            {nMEMRST, nBYTE, nCE, nWE, nOE, req_ready, rsp_valid, init_done, ADDR, rsp_data},
            {(e >= RSTC), 1'b0, !(e >= RSTC + RRC), 1'b1, noe_m, ready_exp, rv_m, init_m, addr_m, rsp_m});
      if (ready_exp && req_valid) begin
        act_m  = 1'b1;
        e0     = e + 1;
        base_m = {req_addr[AW-1:2], 2'b00};
        word_m = flash_word(base_m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_e(input int t);
    @(negedge clk);
    for (int g = 0; g < 40000 && e != t; g++) @(negedge clk);
    check("wait_edge", e, t);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [31:0] w, input string nm);
    int ea;
    step();
    req_addr  = a;
    req_valid = 1'b1;
    ea = e + 1;
    step();
    req_valid = 1'b0;
    req_addr  = 27'h5555555;
    wait_e(ea);
    check({nm, "_addr0"}, {ADDR, nOE}, {b, 1'b0});
    wait_e(ea + ACC);
    check({nm, "_addr1"}, ADDR, b + 27'd1);
    wait_e(ea + 3 * ACC);
    check({nm, "_addr3"}, ADDR, b + 27'd3);
    wait_e(ea + 4 * ACC - 1);
    check({nm, "_no_early_rsp"}, {rsp_valid, nOE}, 2'b00);
    wait_e(ea + 4 * ACC);
    check({nm, "_rsp"}, {rsp_valid, nOE, rsp_data}, {2'b11, w});
    wait_e(ea + 4 * ACC + 1);
    check({nm, "_rsp_end"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  int acc_q[$];
  int p;

  initial begin
    repeat (3) step();
    check("reset_ctrl", {nMEMRST, nBYTE, nCE, nWE, nOE, req_ready, rsp_valid, init_done}, 8'b0011_1000);
    check("reset_data", {ADDR, rsp_data}, '0);
    rst = 1'b0;

    // Power-up sequence.
    wait_e(RSTC - 1);
    check("memrst_low", nMEMRST, 1'b0);
    wait_e(RSTC);
    check("memrst_rise", {nMEMRST, nCE}, 2'b11);
    wait_e(RSTC + 1);
    check("nce_still_high", nCE, 1'b1);
    wait_e(RSTC + 2);
    check("nce_fall", {nCE, init_done}, 2'b00);
    wait_e(RSTC + 3);
    check("init_done", {init_done, req_ready, nWE, nBYTE}, 4'b1110);

    // Aligned, misaligned and top-of-range reads.
    do_read(27'h0000100, 27'h0000100, 32'h44332211, "aligned");
    do_read(27'h0000103, 27'h0000100, 32'h44332211, "misaligned");
    do_read(27'h7FFFFFF, 27'h7FFFFFC, 32'h5A5B5859, "top");

    // Flash busy while idle with a pending request.
    step();
    RDY_BSY = 1'b0;
    repeat (3) step();
    req_addr  = 27'h0000200;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_no_ready", {req_ready, ADDR}, {1'b0, 27'h7FFFFFF});
    end
    step();
    RDY_BSY = 1'b1;
    p = e;
    wait_e(p + 1);
    check("sync_delay", req_ready, 1'b0);
    wait_e(p + 2);
    check("sync_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    RDY_BSY   = 1'b0;
    wait_e(p + 3 + 4 * ACC);
    check("busy_read_rsp", {rsp_valid, rsp_data}, {1'b1, 32'hA6A7A4A5});
    step();
    RDY_BSY = 1'b1;
    repeat (3) step();

    // Back-to-back requests.
    req_addr  = 27'h0000100;
    req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc_q.push_back(e + 1);
      if (rsp_valid) check("b2b_ready_in_rsp", req_ready, 1'b0);
    end
    step();
    req_valid = 1'b0;
    check("b2b_count", acc_q.size() >= 3, 1'b1);
    if (acc_q.size() >= 3) begin
      check("b2b_gap1", acc_q[1] - acc_q[0], 18);
      check("b2b_gap2", acc_q[2] - acc_q[1], 18);
    end
    repeat (20) step();

    // Reset in the middle of a read.
    req_addr  = 27'h0000100;
    req_valid = 1'b1;
    p = e + 1;
    step();
    req_valid = 1'b0;
    wait_e(p + ACC + 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midread_reset", {nOE, nCE, nMEMRST, rsp_valid, init_done, req_ready}, 6'b110000);
    check("midread_reset_addr", ADDR, '0);
    step();
    rst = 1'b0;
    wait_e(RSTC - 1);
    check("re_memrst_low", {nMEMRST, rsp_valid}, 2'b00);
    wait_e(RSTC);
    check("re_memrst_rise", nMEMRST, 1'b1);
    wait_e(RSTC + 3);
    check("re_init_done", {init_done, nCE}, 2'b10);
    do_read(27'h0000101, 27'h0000100, 32'h44332211, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout expected=done");
    $fatal(1);
  end

endmodule
